// File: rtl/instr_dispatch_queue_if.sv
// Instruction handshake bundle between the instruction fetcher (master)
// and instr_dispatch_queue (slave).
//   instr_in    : 64-bit instruction word, opcode in [63:56]
//   instr_valid : producer offers instr_in
//   instr_ready : queue not full; transfer on valid & ready at a rising edge
interface instr_dispatch_queue_if;
  logic [63:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr_in, output instr_valid, input instr_ready);
  modport slave  (input instr_in, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_dispatch_queue.sv
// instr_dispatch_queue: buffers 64-bit instructions in a FIFO, decodes the
// opcode at the head and dispatches one-cycle strobes plus held payload to
// the feature/weight fetchers, the CONV engine and the vector-register file.
// Busy inputs stall the head (strict in-order), 0x44 enters a HOLD barrier,
// 0x82 ends execution, unknown opcodes raise illegal_opcode.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   instr_if (slave)   : instr_in / instr_valid / instr_ready handshake
//   fetch_busy         : fetch units busy (stalls FETCH, holds HOLD)
//   comp_busy          : compute engine busy (stalls CONV, holds HOLD)
//   fifo_level         : queue occupancy
//   *_fetch_enable     : fetch strobes; fetch_type/src_addr/dst_addr/
//                        mem_sel/fetch_counter are the fetch payload
//   conv_cfg_valid     : CONV strobe; kernel_size/feature_size/
//                        line_buffer_enable/feature_in_select/
//                        line_buffer_mod are the CONV payload
//   kn_cfg_valid       : kernel-mode strobe, kn_size_mode payload
//   reg_enable, vreg_input_select : vector-register control levels
//   exe_done           : sticky completion after 0x82
//   illegal_opcode     : one-cycle strobe for an unknown opcode
//   hold_timeout       : one-cycle HOLD watchdog strobe
//
// Build option: define INSTR_DECODE_TIMEOUT_EN to build the HOLD watchdog
// (HOLD_TIMEOUT cycles). Without it HOLD waits indefinitely and
// hold_timeout is constant 0.
module instr_dispatch_queue #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned HOLD_TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  instr_dispatch_queue_if.slave           instr_if,
  input  logic                            fetch_busy,
  input  logic                            comp_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            feature_fetch_enable,
  output logic                            weight_fetch_enable,
  output logic                            bias_fetch_enable,
  output logic                            scaler_fetch_enable,
  output logic [7:0]                      fetch_type,
  output logic [15:0]                     src_addr,
  output logic [7:0]                      dst_addr,
  output logic [7:0]                      mem_sel,
  output logic [7:0]                      fetch_counter,
  output logic                            conv_cfg_valid,
  output logic [3:0]                      kernel_size,
  output logic [7:0]                      feature_size,
  output logic                            line_buffer_enable,
  output logic                            feature_in_select,
  output logic                            line_buffer_mod,
  output logic                            kn_cfg_valid,
  output logic [1:0]                      kn_size_mode,
  output logic                            reg_enable,
  output logic                            vreg_input_select,
  output logic                            exe_done,
  output logic                            illegal_opcode,
  output logic                            hold_timeout
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_FETCH_A = 8'h02;
  localparam logic [7:0] OP_FETCH_B = 8'h04;
  localparam logic [7:0] OP_KMODE   = 8'h20;
  localparam logic [7:0] OP_VREG    = 8'h40;
  localparam logic [7:0] OP_HOLD    = 8'h44;
  localparam logic [7:0] OP_CONV    = 8'h81;
  localparam logic [7:0] OP_END     = 8'h82;

  typedef enum logic [1:0] {
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t state;

  // ---------------------------------------------------------------- FIFO
  logic [63:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             push;
  logic             pop;

  assign push = instr_if.instr_valid & instr_if.instr_ready;

  always_comb begin
    level_nxt = fifo_level;
    case ({push, pop})
      2'b10:   level_nxt = fifo_level + 1'b1;
      2'b01:   level_nxt = fifo_level - 1'b1;
      default: level_nxt = fifo_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= instr_if.instr_in;
    end
  end

  // instr_ready is registered from the next level so it is exactly !full
  // in every cycle; pointers wrap naturally because FIFO_DEPTH is 2**PTR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_level         <= '0;
      instr_if.instr_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level           <= level_nxt;
      instr_if.instr_ready <= (level_nxt != LVL_W'(FIFO_DEPTH));
    end
  end

  // ---------------------------------------------------------------- decode
  logic [63:0] head;
  logic [7:0]  opcode;
  logic [7:0]  r1, r2, r3, r4, r5, r6, r7;

  assign head   = mem[rd_ptr];
  assign opcode = head[63:56];
  assign r1     = head[55:48];
  assign r2     = head[47:40];
  assign r3     = head[39:32];
  assign r4     = head[31:24];
  assign r5     = head[23:16];
  assign r6     = head[15:8];
  assign r7     = head[7:0];

  // Busy inputs are sampled combinationally, so a busy rising in the
  // dispatch cycle blocks that dispatch.
  always_comb begin
    pop = 1'b0;
    if (state == S_RUN && fifo_level != '0) begin
      case (opcode)
        OP_FETCH_A, OP_FETCH_B: pop = !fetch_busy;
        OP_CONV:                pop = !comp_busy;
        default:                pop = 1'b1;
      endcase
    end
  end

`ifdef INSTR_DECODE_TIMEOUT_EN
  localparam logic [15:0] HOLD_LIMIT = 16'(HOLD_TIMEOUT - 1);
  logic [15:0] hold_cnt;

  logic unused_bits;
  assign unused_bits = ^{r4[7:4], r5[7:4]};
`else
  assign hold_timeout = 1'b0;

  // HOLD_TIMEOUT only matters for the watchdog build.
  logic unused_bits;
  assign unused_bits = ^{r4[7:4], r5[7:4], 16'(HOLD_TIMEOUT)};
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_RUN;
      feature_fetch_enable <= 1'b0;
      weight_fetch_enable  <= 1'b0;
      bias_fetch_enable    <= 1'b0;
      scaler_fetch_enable  <= 1'b0;
      fetch_type           <= '0;
      src_addr             <= '0;
      dst_addr             <= '0;
      mem_sel              <= '0;
      fetch_counter        <= '0;
      conv_cfg_valid       <= 1'b0;
      kernel_size          <= '0;
      feature_size         <= '0;
      line_buffer_enable   <= 1'b0;
      feature_in_select    <= 1'b0;
      line_buffer_mod      <= 1'b0;
      kn_cfg_valid         <= 1'b0;
      kn_size_mode         <= '0;
      reg_enable           <= 1'b0;
      vreg_input_select    <= 1'b0;
      exe_done             <= 1'b0;
      illegal_opcode       <= 1'b0;
`ifdef INSTR_DECODE_TIMEOUT_EN
      hold_timeout         <= 1'b0;
      hold_cnt             <= '0;
`endif
    end else begin
      feature_fetch_enable <= 1'b0;
      weight_fetch_enable  <= 1'b0;
      bias_fetch_enable    <= 1'b0;
      scaler_fetch_enable  <= 1'b0;
      conv_cfg_valid       <= 1'b0;
      kn_cfg_valid         <= 1'b0;
      illegal_opcode       <= 1'b0;
`ifdef INSTR_DECODE_TIMEOUT_EN
      hold_timeout         <= 1'b0;
`endif
      case (state)
        S_RUN: begin
          if (pop) begin
            case (opcode)
              OP_FETCH_A, OP_FETCH_B: begin
                feature_fetch_enable <= (r1 == 8'h00);
                weight_fetch_enable  <= r1[0];
                bias_fetch_enable    <= r1[1];
                scaler_fetch_enable  <= r1[2];
                fetch_type           <= r1;
                src_addr             <= {r2, r3};
                dst_addr             <= {r4[3:0], r5[3:0]};
                mem_sel              <= r6;
                fetch_counter        <= r7;
              end
              OP_CONV: begin
                conv_cfg_valid     <= 1'b1;
                feature_size       <= r2;
                kernel_size        <= r3[3:0];
                line_buffer_enable <= r4[0];
                feature_in_select  <= r6[0];
                line_buffer_mod    <= r1[0];
              end
              OP_VREG: begin
                reg_enable        <= r1[0];
                vreg_input_select <= r2[0];
                line_buffer_mod   <= r3[0];
              end
              OP_KMODE: begin
                kn_cfg_valid <= 1'b1;
                kn_size_mode <= r1[1:0];
              end
              OP_HOLD: begin
                state <= S_HOLD;
`ifdef INSTR_DECODE_TIMEOUT_EN
                hold_cnt <= '0;
`endif
              end
              OP_END: begin
                exe_done <= 1'b1;
                state    <= S_DONE;
              end
              OP_NOP: ;
              default: illegal_opcode <= 1'b1;
            endcase
          end
        end
        S_HOLD: begin
          if (!fetch_busy && !comp_busy) begin
            state <= S_RUN;
          end
`ifdef INSTR_DECODE_TIMEOUT_EN
          else if (hold_cnt == HOLD_LIMIT) begin
            hold_timeout <= 1'b1;
            state        <= S_RUN;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
`endif
        end
        S_DONE: ;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_dispatch_queue.sv
module tb_instr_dispatch_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch_busy = 1'b0;
  logic       comp_busy = 1'b0;
  logic [2:0] fifo_level;
  logic       feature_fetch_enable, weight_fetch_enable;
  logic       bias_fetch_enable, scaler_fetch_enable;
  logic [7:0] fetch_type, dst_addr, mem_sel, fetch_counter, feature_size;
  logic [15:0] src_addr;
  logic       conv_cfg_valid, line_buffer_enable, feature_in_select;
  logic       line_buffer_mod, kn_cfg_valid, reg_enable, vreg_input_select;
  logic [3:0] kernel_size;
  logic [1:0] kn_size_mode;
  logic       exe_done, illegal_opcode, hold_timeout;

  int passed = 0;
  int total  = 0;

  instr_dispatch_queue_if ifc ();

  instr_dispatch_queue #(
    .FIFO_DEPTH  (DEPTH),
    .HOLD_TIMEOUT(4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instr_if            (ifc),
    .fetch_busy          (fetch_busy),
    .comp_busy           (comp_busy),
    .fifo_level          (fifo_level),
    .feature_fetch_enable(feature_fetch_enable),
    .weight_fetch_enable (weight_fetch_enable),
    .bias_fetch_enable   (bias_fetch_enable),
    .scaler_fetch_enable (scaler_fetch_enable),
    .fetch_type          (fetch_type),
    .src_addr            (src_addr),
    .dst_addr            (dst_addr),
    .mem_sel             (mem_sel),
    .fetch_counter       (fetch_counter),
    .conv_cfg_valid      (conv_cfg_valid),
    .kernel_size         (kernel_size),
    .feature_size        (feature_size),
    .line_buffer_enable  (line_buffer_enable),
    .feature_in_select   (feature_in_select),
    .line_buffer_mod     (line_buffer_mod),
    .kn_cfg_valid        (kn_cfg_valid),
    .kn_size_mode        (kn_size_mode),
    .reg_enable          (reg_enable),
    .vreg_input_select   (vreg_input_select),
    .exe_done            (exe_done),
    .illegal_opcode      (illegal_opcode),
    .hold_timeout        (hold_timeout)
  );

  always #5 clk = ~clk;

  logic [78:0] outs;
  assign outs = {feature_fetch_enable, weight_fetch_enable, bias_fetch_enable,
                 scaler_fetch_enable, fetch_type, src_addr, dst_addr, mem_sel,
                 fetch_counter, conv_cfg_valid, kernel_size, feature_size,
                 line_buffer_enable, feature_in_select, line_buffer_mod,
                 kn_cfg_valid, kn_size_mode, reg_enable, vreg_input_select,
                 exe_done, illegal_opcode, hold_timeout, fifo_level};

  localparam logic [63:0] W_FETCH1 = 64'h04_01_12_34_05_06_02_10;
  localparam logic [63:0] W_FETCH2 = 64'h02_00_AB_CD_0F_0E_01_03;
  localparam logic [63:0] W_CONV1  = 64'h81_01_20_05_01_00_01_00;
  localparam logic [63:0] W_CONV2  = 64'h81_00_10_03_00_00_00_00;
  localparam logic [63:0] W_HOLD   = 64'h44_00_00_00_00_00_00_00;
  localparam logic [63:0] W_END    = 64'h82_00_00_00_00_00_00_00;
  localparam logic [63:0] W_ILL    = 64'h7F_00_00_00_00_00_00_00;
  localparam logic [63:0] W_VREG1  = 64'h40_01_01_01_00_00_00_00;
  localparam logic [63:0] W_VREG0  = 64'h40_00_00_00_00_00_00_00;

  function automatic logic [63:0] kmode(input logic [7:0] r1);
    return {8'h20, r1, 48'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] w);
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = w;
    tick();
    ifc.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.instr_valid = 1'b0;
    ifc.instr_in = '0;
    tick();
    tick();
    total++;
    if (outs !== '0) $display("FAIL reset_outs: got %h want 0", outs);
    else passed++;
    total++;
    if (ifc.instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ifc.instr_ready);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    push(W_FETCH1);
    total++;
    if (fifo_level !== 3'd1 || weight_fetch_enable !== 1'b0)
      $display("FAIL fetch_accept: level %0d wfe %b want 1 0", fifo_level, weight_fetch_enable);
    else passed++;
    tick();
    total++;
    if ({weight_fetch_enable, feature_fetch_enable, bias_fetch_enable, scaler_fetch_enable} !== 4'b1000)
      $display("FAIL fetch_strobes: got %b want 1000",
               {weight_fetch_enable, feature_fetch_enable, bias_fetch_enable, scaler_fetch_enable});
    else passed++;
    total++;
    if ({fetch_type, src_addr, dst_addr, mem_sel, fetch_counter} !== 48'h01_1234_56_02_10)
      $display("FAIL fetch_payload: got %h want 0112345602 10",
               {fetch_type, src_addr, dst_addr, mem_sel, fetch_counter});
    else passed++;
    tick();
    total++;
    if (weight_fetch_enable !== 1'b0 || src_addr !== 16'h1234 || fifo_level !== 3'd0)
      $display("FAIL fetch_oneshot: wfe %b src %h lvl %0d want 0 1234 0",
               weight_fetch_enable, src_addr, fifo_level);
    else passed++;
  endtask

  task automatic test_stall();
    fetch_busy = 1'b1;
    push(W_FETCH2);
    push(kmode(8'h01));
    tick();
    total++;
    if (fifo_level !== 3'd2 || feature_fetch_enable !== 1'b0 || kn_cfg_valid !== 1'b0)
      $display("FAIL stall_hold: lvl %0d ffe %b kn %b want 2 0 0",
               fifo_level, feature_fetch_enable, kn_cfg_valid);
    else passed++;
    fetch_busy = 1'b0;
    tick();
    total++;
    if (feature_fetch_enable !== 1'b1 || src_addr !== 16'hABCD || dst_addr !== 8'hFE ||
        kn_cfg_valid !== 1'b0 || fifo_level !== 3'd1)
      $display("FAIL stall_release: ffe %b src %h dst %h kn %b lvl %0d want 1 abcd fe 0 1",
               feature_fetch_enable, src_addr, dst_addr, kn_cfg_valid, fifo_level);
    else passed++;
    tick();
    total++;
    if (kn_cfg_valid !== 1'b1 || kn_size_mode !== 2'd1 || feature_fetch_enable !== 1'b0)
      $display("FAIL stall_kmode: kn %b mode %0d ffe %b want 1 1 0",
               kn_cfg_valid, kn_size_mode, feature_fetch_enable);
    else passed++;
  endtask

  task automatic test_full();
    comp_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(W_CONV1);
    total++;
    if (fifo_level !== 3'(DEPTH) || ifc.instr_ready !== 1'b0 || conv_cfg_valid !== 1'b0)
      $display("FAIL full_level: lvl %0d rdy %b conv %b want %0d 0 0",
               fifo_level, ifc.instr_ready, conv_cfg_valid, DEPTH);
    else passed++;
    push(kmode(8'h02));
    total++;
    if (fifo_level !== 3'(DEPTH)) $display("FAIL full_reject: lvl %0d want %0d", fifo_level, DEPTH);
    else passed++;
    comp_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      total++;
      if (conv_cfg_valid !== 1'b1 || fifo_level !== 3'(DEPTH - 1 - i))
        $display("FAIL full_drain%0d: conv %b lvl %0d want 1 %0d",
                 i, conv_cfg_valid, fifo_level, DEPTH - 1 - i);
      else passed++;
    end
    total++;
    if ({feature_size, kernel_size, line_buffer_enable, feature_in_select, line_buffer_mod,
         ifc.instr_ready} !== {8'h20, 4'd5, 4'b1111})
      $display("FAIL conv_payload: fs %h ks %0d lbe %b fis %b lbm %b rdy %b want 20 5 1 1 1 1",
               feature_size, kernel_size, line_buffer_enable, feature_in_select,
               line_buffer_mod, ifc.instr_ready);
    else passed++;
    tick();
    total++;
    if (conv_cfg_valid !== 1'b0 || kn_cfg_valid !== 1'b0 || kn_size_mode !== 2'd1)
      $display("FAIL full_after: conv %b kn %b mode %0d want 0 0 1",
               conv_cfg_valid, kn_cfg_valid, kn_size_mode);
    else passed++;
  endtask

  task automatic test_back_to_back();
    push(W_VREG1);
    push(kmode(8'h02));
    total++;
    if (reg_enable !== 1'b1 || vreg_input_select !== 1'b1 || line_buffer_mod !== 1'b1 ||
        fifo_level !== 3'd1)
      $display("FAIL b2b_vreg: re %b vis %b lbm %b lvl %0d want 1 1 1 1",
               reg_enable, vreg_input_select, line_buffer_mod, fifo_level);
    else passed++;
    push(kmode(8'h00));
    total++;
    if (kn_cfg_valid !== 1'b1 || kn_size_mode !== 2'd2 || fifo_level !== 3'd1)
      $display("FAIL b2b_k1: kn %b mode %0d lvl %0d want 1 2 1", kn_cfg_valid, kn_size_mode, fifo_level);
    else passed++;
    tick();
    total++;
    if (kn_cfg_valid !== 1'b1 || kn_size_mode !== 2'd0 || fifo_level !== 3'd0)
      $display("FAIL b2b_k2: kn %b mode %0d lvl %0d want 1 0 0", kn_cfg_valid, kn_size_mode, fifo_level);
    else passed++;
    tick();
    total++;
    if (kn_cfg_valid !== 1'b0 || reg_enable !== 1'b1)
      $display("FAIL b2b_end: kn %b re %b want 0 1", kn_cfg_valid, reg_enable);
    else passed++;
  endtask

  task automatic test_hold();
    comp_busy = 1'b1;
    push(W_HOLD);
    push(W_CONV2);
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++;
`ifdef INSTR_DECODE_TIMEOUT_EN
      if (conv_cfg_valid !== 1'b0 || hold_timeout !== (i == 4))
        $display("FAIL hold_wait%0d: conv %b hto %b want 0 %b", i, conv_cfg_valid, hold_timeout, i == 4);
`else
      if (conv_cfg_valid !== 1'b0 || hold_timeout !== 1'b0 || fifo_level !== 3'd1)
        $display("FAIL hold_wait%0d: conv %b hto %b lvl %0d want 0 0 1",
                 i, conv_cfg_valid, hold_timeout, fifo_level);
`endif
      else passed++;
    end
    comp_busy = 1'b0;
`ifndef INSTR_DECODE_TIMEOUT_EN
    tick();
    total++;
    if (conv_cfg_valid !== 1'b0) $display("FAIL hold_exit: conv %b want 0", conv_cfg_valid);
    else passed++;
`endif
    tick();
    total++;
    if (conv_cfg_valid !== 1'b1 || feature_size !== 8'h10 || kernel_size !== 4'd3 ||
        line_buffer_mod !== 1'b0 || fifo_level !== 3'd0)
      $display("FAIL hold_conv: conv %b fs %h ks %0d lbm %b lvl %0d want 1 10 3 0 0",
               conv_cfg_valid, feature_size, kernel_size, line_buffer_mod, fifo_level);
    else passed++;
  endtask

  task automatic test_illegal_end();
    push(W_ILL);
    push(W_END);
    total++;
    if (illegal_opcode !== 1'b1 || src_addr !== 16'hABCD || feature_size !== 8'h10 ||
        exe_done !== 1'b0)
      $display("FAIL illegal_pulse: ill %b src %h fs %h done %b want 1 abcd 10 0",
               illegal_opcode, src_addr, feature_size, exe_done);
    else passed++;
    push(W_VREG0);
    total++;
    if (illegal_opcode !== 1'b0 || exe_done !== 1'b1 || fifo_level !== 3'd1)
      $display("FAIL end_done: ill %b done %b lvl %0d want 0 1 1", illegal_opcode, exe_done, fifo_level);
    else passed++;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (exe_done !== 1'b1 || reg_enable !== 1'b1 || fifo_level !== 3'd1 || illegal_opcode !== 1'b0)
      $display("FAIL done_sticky: done %b re %b lvl %0d ill %b want 1 1 1 0",
               exe_done, reg_enable, fifo_level, illegal_opcode);
    else passed++;
  endtask

  task automatic test_reset_mid_hold();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (exe_done !== 1'b0) $display("FAIL rst_clears_done: got %b want 0", exe_done);
    else passed++;
    comp_busy = 1'b1;
    push(W_HOLD);
    push(W_CONV1);
    push(W_CONV1);
    push(W_CONV1);
    total++;
    if (fifo_level !== 3'd3) $display("FAIL hold_level: got %0d want 3", fifo_level);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (outs !== '0 || ifc.instr_ready !== 1'b1)
      $display("FAIL rst_mid: outs %h rdy %b want 0 1", outs, ifc.instr_ready);
    else passed++;
    push(kmode(8'h02));
    tick();
    total++;
    if (kn_cfg_valid !== 1'b1 || kn_size_mode !== 2'd2 || conv_cfg_valid !== 1'b0)
      $display("FAIL rst_run: kn %b mode %0d conv %b want 1 2 0", kn_cfg_valid, kn_size_mode, conv_cfg_valid);
    else passed++;
    comp_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifc.instr_valid = 1'b0;
    ifc.instr_in    = '0;
    test_reset();
    test_fetch();
    test_stall();
    test_full();
    test_back_to_back();
    test_hold();
    test_illegal_end();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
